// File: rtl/classify_ctrl.sv
// Sequencing controller for the LeNet-5 argmax stage: clears and runs the argmax
// unit per scored image and queues {tag, class} results in a small drain FIFO.
module classify_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_WIDTH  = 16,
  parameter int TIMEOUT    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fc_done,
  output logic                 fc_hold,
  output logic                 argmax_clr,
  output logic                 argmax_en,
  input  logic                 argmax_done,
  input  logic [3:0]           argmax_result,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [3:0]           res_class,
  output logic [TAG_WIDTH-1:0] res_tag,
  output logic [TAG_WIDTH-1:0] img_count,
  output logic                 busy,
  output logic [1:0]           err,
  input  logic                 clr_err,
  output logic [2:0]           dbg_state
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int DW = TAG_WIDTH + 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_CLEAR   = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  logic [2:0]           r_state;
  logic [TW-1:0]        r_cnt;
  logic [3:0]           r_result;
  logic [DW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr;
  logic [AW-1:0]        r_rd;
  logic [CW-1:0]        r_count;
  logic                 r_res_valid;
  logic [3:0]           r_res_class;
  logic [TAG_WIDTH-1:0] r_res_tag;
  logic [TAG_WIDTH-1:0] r_img_count;
  logic                 r_fc_hold;
  logic                 r_argmax_clr;
  logic                 r_argmax_en;
  logic                 r_busy;
  logic [1:0]           r_err;

  logic [2:0]    w_nxt;
  logic          w_timeout;
  logic          w_overrun;
  logic          w_pop;
  logic          w_push;
  logic          w_full;
  logic          w_space;
  logic [AW-1:0] w_rd_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [DW-1:0] w_push_data;
  logic [DW-1:0] w_head;

  assign w_pop       = r_res_valid & res_ready;
  assign w_push      = (r_state == S_CAPTURE);
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  // A pop in the same cycle frees a slot at the same edge, so it counts as space.
  assign w_space     = !w_full || w_pop;
  assign w_overrun   = fc_done && (r_state != S_IDLE);
  assign w_push_data = {r_img_count, r_result};
  assign w_rd_nxt    = w_pop ? r_rd + AW'(1) : r_rd;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  assign w_head      = (w_push && (r_wr == w_rd_nxt)) ? w_push_data : r_mem[w_rd_nxt];

  always_comb begin
    w_nxt     = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:    if (fc_done) w_nxt = w_space ? S_CLEAR : S_WAIT;
      S_WAIT:    if (w_space) w_nxt = S_CLEAR;
      S_CLEAR:   w_nxt = S_RUN;
      S_RUN: begin
        if (argmax_done) begin
          w_nxt = S_CAPTURE;
        end else if (r_cnt == TW'(TIMEOUT - 1)) begin
          w_nxt     = S_RELEASE;
          w_timeout = 1'b1;
        end
      end
      S_CAPTURE: w_nxt = S_RELEASE;
      S_RELEASE: if (r_cnt == TW'(1)) w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_result     <= '0;
      r_wr         <= '0;
      r_rd         <= '0;
      r_count      <= '0;
      r_res_valid  <= 1'b0;
      r_res_class  <= '0;
      r_res_tag    <= '0;
      r_img_count  <= '0;
      r_fc_hold    <= 1'b0;
      r_argmax_clr <= 1'b0;
      r_argmax_en  <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= (w_nxt != r_state) ? '0 : r_cnt + TW'(1);
      if (r_state == S_RUN && argmax_done) r_result <= argmax_result;
      if (w_push) begin
        r_wr        <= r_wr + AW'(1);
        r_img_count <= r_img_count + TAG_WIDTH'(1);
      end
      r_rd        <= w_rd_nxt;
      r_count     <= w_count_nxt;
      r_res_valid <= (w_count_nxt != '0);
      if (w_push || w_pop) begin
        r_res_tag   <= w_head[DW-1:4];
        r_res_class <= w_head[3:0];
      end
      // Outputs are decoded from the next state so they line up with it.
      r_argmax_clr <= (w_nxt == S_CLEAR);
      r_argmax_en  <= (w_nxt == S_RUN);
      r_fc_hold    <= (w_nxt == S_WAIT) || (w_nxt == S_CLEAR) ||
                      (w_nxt == S_RUN)  || (w_nxt == S_CAPTURE);
      r_busy       <= (w_nxt != S_IDLE);
      r_err        <= (clr_err ? 2'b00 : r_err) | {w_overrun, w_timeout};
    end
  end

  assign fc_hold    = r_fc_hold;
  assign argmax_clr = r_argmax_clr;
  assign argmax_en  = r_argmax_en;
  assign res_valid  = r_res_valid;
  assign res_class  = r_res_class;
  assign res_tag    = r_res_tag;
  assign img_count  = r_img_count;
  assign busy       = r_busy;
  assign err        = r_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_classify_ctrl.sv
// Directed bench for classify_ctrl with a behavioural argmax unit and a
// result scoreboard checked by an independent pop monitor.
module tb_classify_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fc_done = 1'b0;
  logic        res_ready = 1'b0;
  logic        clr_err = 1'b0;
  logic        fc_hold, argmax_clr, argmax_en, argmax_done, res_valid, busy;
  logic [3:0]  argmax_result, res_class;
  logic [15:0] res_tag, img_count;
  logic [1:0]  err;
  logic [2:0]  dbg_state;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [19:0] exp_q[$];
  logic [15:0] next_tag = '0;

  logic [3:0]  m_class = '0;
  logic        m_stall = 1'b0;
  logic [3:0]  m_cnt = '0;
  logic        m_done = 1'b0;

  assign argmax_done   = m_done;
  assign argmax_result = m_class;

  classify_ctrl #(.FIFO_DEPTH(4), .TAG_WIDTH(16), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst), .fc_done(fc_done), .fc_hold(fc_hold),
    .argmax_clr(argmax_clr), .argmax_en(argmax_en), .argmax_done(argmax_done),
    .argmax_result(argmax_result), .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_tag(res_tag), .img_count(img_count),
    .busy(busy), .err(err), .clr_err(clr_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // argmax unit: done rises on the 11th enabled cycle and holds until cleared
  always @(posedge clk) begin
    if (argmax_clr) begin
      m_cnt  <= '0;
      m_done <= 1'b0;
    end else if (argmax_en && !m_done && !m_stall) begin
      if (m_cnt == 4'd9) m_done <= 1'b1;
      m_cnt <= m_cnt + 4'd1;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst && res_valid && res_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected at cycle %0d: got tag %0d class %0d, expected nothing", cyc, res_tag, res_class);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({res_tag, res_class} !== e) begin
          miscompares++;
          $display("FAIL pop_data at cycle %0d: got tag %0d class %0d, expected tag %0d class %0d",
                   cyc, res_tag, res_class, e[19:4], e[3:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    exp_q.delete();
    next_tag = '0;
    rst = 1'b1;
  endtask

  task automatic issue(input logic [3:0] cls, input bit ok);
    if (ok) begin
      m_class = cls;
      exp_q.push_back({next_tag, cls});
      next_tag++;
    end
    fc_done = 1'b1;
    step();
    fc_done = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check("wait_idle", 32'(busy), 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    res_ready = 1'b1;
    while (res_valid && n < 20) begin
      step();
      n++;
    end
    res_ready = 1'b0;
    check("drain_empty", 32'(res_valid), 0);
    check("exp_q_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int en_cnt;
    int rel_cnt;
    int n;

    // reset state
    step();
    step();
    check("rst_valid", 32'(res_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_hold", 32'(fc_hold), 0);
    check("rst_en", 32'(argmax_en), 0);
    check("rst_err", 32'(err), 0);
    check("rst_count", 32'(img_count), 0);
    rst = 1'b1;
    cyc = 0;

    // single image, fc_done in cycle 5
    repeat (5) step();
    issue(4'd7, 1'b1);
    for (int c = 6; c <= 22; c++) begin
      check("t1_clr", 32'(argmax_clr), 32'(c == 6));
      check("t1_en", 32'(argmax_en), 32'(c >= 7 && c <= 17));
      check("t1_hold", 32'(fc_hold), 32'(c >= 6 && c <= 18));
      check("t1_busy", 32'(busy), 32'(c >= 6 && c <= 20));
      if (c == 18) check("t1_valid_pre", 32'(res_valid), 0);
      if (c == 19) begin
        check("t1_valid", 32'(res_valid), 1);
        check("t1_class", 32'(res_class), 7);
        check("t1_tag", 32'(res_tag), 0);
        check("t1_count", 32'(img_count), 1);
      end
      step();
    end
    drain();

    // back-pressure: five images at minimum period, consumer stalled
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(4'(2 * i + 1), 1'b1);
      repeat (15) step();
    end
    issue(4'd9, 1'b1);
    check("t2_wait_state", 32'(dbg_state), 1);
    check("t2_wait_hold", 32'(fc_hold), 1);
    check("t2_wait_en", 32'(argmax_en), 0);
    repeat (4) step();
    check("t2_still_wait", 32'(dbg_state), 1);
    check("t2_still_en", 32'(argmax_en), 0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("t2_clear_after_pop", 32'(argmax_clr), 1);
    wait_idle(40);
    check("t2_count", 32'(img_count), 5);
    drain();

    // timeout: argmax never finishes
    m_stall = 1'b1;
    issue(4'd2, 1'b0);
    en_cnt = 0;
    rel_cnt = 0;
    n = 0;
    while (busy && n < 80) begin
      if (argmax_en) en_cnt++;
      if (dbg_state == 3'd5) rel_cnt++;
      step();
      n++;
    end
    m_stall = 1'b0;
    check("t3_en_cycles", 32'(en_cnt), 32);
    check("t3_release_cycles", 32'(rel_cnt), 2);
    check("t3_err", 32'(err), 1);
    check("t3_no_push", 32'(res_valid), 0);
    check("t3_count", 32'(img_count), 5);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("t3_clr_err", 32'(err), 0);

    // overrun: second fc_done during RUN
    issue(4'd3, 1'b1);
    repeat (7) step();
    fc_done = 1'b1;
    step();
    fc_done = 1'b0;
    check("t4_err", 32'(err), 2);
    wait_idle(40);
    check("t4_valid", 32'(res_valid), 1);
    drain();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("t4_clr", 32'(err), 0);
    issue(4'd6, 1'b1);
    repeat (5) step();
    fc_done = 1'b1;
    clr_err = 1'b1;
    step();
    fc_done = 1'b0;
    clr_err = 1'b0;
    check("t4_clr_vs_new", 32'(err), 2);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("t4_clr2", 32'(err), 0);
    wait_idle(40);
    drain();

    // simultaneous push and pop with one entry queued
    issue(4'd2, 1'b1);
    wait_idle(40);
    check("t5_one_entry", 32'(res_valid), 1);
    issue(4'd5, 1'b1);
    repeat (12) step();
    check("t5_capture", 32'(dbg_state), 4);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("t5_valid", 32'(res_valid), 1);
    check("t5_class", 32'(res_class), 5);
    check("t5_tag", 32'(res_tag), 8);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("t5_count_one", 32'(res_valid), 0);
    check("t5_q_empty", 32'(exp_q.size()), 0);
    wait_idle(40);

    // asynchronous reset in RUN with two results queued
    issue(4'd1, 1'b1);
    wait_idle(40);
    issue(4'd4, 1'b1);
    wait_idle(40);
    issue(4'd8, 1'b0);
    repeat (4) step();
    check("t6_running", 32'(argmax_en), 1);
    #2 rst = 1'b0;
    #1;
    check("t6_en", 32'(argmax_en), 0);
    check("t6_hold", 32'(fc_hold), 0);
    check("t6_valid", 32'(res_valid), 0);
    check("t6_count", 32'(img_count), 0);
    check("t6_busy", 32'(busy), 0);
    exp_q.delete();
    next_tag = '0;
    step();
    step();
    rst = 1'b1;
    step();
    issue(4'd9, 1'b1);
    wait_idle(40);
    check("t6_tag", 32'(res_tag), 0);
    check("t6_class", 32'(res_class), 9);
    check("t6_img_count", 32'(img_count), 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
